// File: rtl/change_hopper_if.sv
// Request/hopper handshake bundle between the vend FSM, the coin hopper and the change controller.
interface change_hopper_if #(
  parameter int AMT_W = 6
);
  logic             req_valid;
  logic             req_ready;
  logic [AMT_W-1:0] req_amt;
  logic             eject_nickel;
  logic             eject_dime;
  logic             hopper_ack;
  logic             done;
  logic             short;
  logic [AMT_W-1:0] remain;

  modport master (
    output req_valid, req_amt, hopper_ack,
    input  req_ready, eject_nickel, eject_dime, done, short, remain
  );

  modport slave (
    input  req_valid, req_amt, hopper_ack,
    output req_ready, eject_nickel, eject_dime, done, short, remain
  );
endinterface

// File: rtl/change_hopper_ctrl.sv
// Coin-change hopper sequencer: pays change dimes-first, one coin per hopper ack, owns the inventory.
// Optional jam retry (one re-pulse of the stuck coin) is enabled by CHANGE_HOPPER_JAM_RETRY_EN.
module change_hopper_ctrl #(
  parameter int CNT_W       = 8,
  parameter int AMT_W       = 6,
  parameter int ACK_TIMEOUT = 16,
  parameter int GAP_CYCLES  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_coins,
  input  logic [CNT_W-1:0] nickels,
  input  logic [CNT_W-1:0] dimes,
  change_hopper_if.slave   hop,
  output logic [CNT_W-1:0] nickel_cnt,
  output logic [CNT_W-1:0] dime_cnt,
  output logic             exact_only
);
  localparam int TMR_MAX = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  typedef enum logic [2:0] {IDLE, SELECT, EJECT, WAIT_ACK, GAP, FINISH} state_t;

  state_t           state, next_state;
  logic [AMT_W-1:0] remain;
  logic [TMR_W-1:0] timer;
  logic             pick_dime;
  logic             retry;
  logic             ready;
  logic             can_dime, can_nickel, ack_timeout, gap_end;
  logic             ej_nickel, ej_dime, done, short_pay;

  assign ready       = (state == IDLE) && !load_coins;
  assign can_dime    = (remain >= AMT_W'(2)) && (dime_cnt != '0);
  assign can_nickel  = (nickel_cnt != '0);
  assign ack_timeout = (timer == TMR_W'(ACK_TIMEOUT - 1));
  assign gap_end     = (timer == TMR_W'(GAP_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    ej_nickel  = 1'b0;
    ej_dime    = 1'b0;
    done       = 1'b0;
    short_pay  = 1'b0;
    case (state)
      IDLE: begin
        if (hop.req_valid && ready)
          next_state = (hop.req_amt == '0) ? FINISH : SELECT;
      end
      SELECT:   next_state = (can_dime || can_nickel) ? EJECT : FINISH;
      EJECT: begin
        ej_dime    = pick_dime;
        ej_nickel  = !pick_dime;
        next_state = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (hop.hopper_ack) begin
          next_state = GAP;
        end else if (ack_timeout) begin
`ifdef CHANGE_HOPPER_JAM_RETRY_EN
          next_state = retry ? FINISH : EJECT;
`else
          next_state = FINISH;
`endif
        end
      end
      GAP: begin
        if (gap_end) next_state = (remain == '0) ? FINISH : SELECT;
      end
      FINISH: begin
        done       = 1'b1;
        short_pay  = (remain != '0);
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Inventory, owed amount and the shared ack/gap timer; a retried coin is not decremented twice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nickel_cnt <= '0;
      dime_cnt   <= '0;
      remain     <= '0;
      timer      <= '0;
      pick_dime  <= 1'b0;
      retry      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_coins) begin
            nickel_cnt <= nickels;
            dime_cnt   <= dimes;
          end else if (hop.req_valid) begin
            remain <= hop.req_amt;
          end
        end
        SELECT: begin
          pick_dime <= can_dime;
          retry     <= 1'b0;
        end
        EJECT: begin
          timer <= '0;
          if (!retry) begin
            if (pick_dime) dime_cnt   <= dime_cnt - CNT_W'(1);
            else           nickel_cnt <= nickel_cnt - CNT_W'(1);
          end
        end
        WAIT_ACK: begin
          if (hop.hopper_ack) begin
            remain <= remain - (pick_dime ? AMT_W'(2) : AMT_W'(1));
            timer  <= '0;
          end else if (ack_timeout) begin
`ifdef CHANGE_HOPPER_JAM_RETRY_EN
            retry <= 1'b1;
`endif
            timer <= '0;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        GAP:     timer <= timer + TMR_W'(1);
        default: ;
      endcase
    end
  end

  assign hop.req_ready    = ready;
  assign hop.eject_nickel = ej_nickel;
  assign hop.eject_dime   = ej_dime;
  assign hop.done         = done;
  assign hop.short        = short_pay;
  assign hop.remain       = remain;
  assign exact_only       = (nickel_cnt == '0) || (dime_cnt == '0);
endmodule

// File: tb/tb_change_hopper_ctrl.sv
// Directed, table-driven bench for change_hopper_ctrl with a small responsive hopper model.
module tb_change_hopper_ctrl;
  localparam int CNT_W = 8;
  localparam int AMT_W = 6;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             load_coins;
  logic [CNT_W-1:0] nickels, dimes;
  logic [CNT_W-1:0] nickel_cnt, dime_cnt;
  logic             exact_only;

  change_hopper_if #(.AMT_W(AMT_W)) hop ();

  change_hopper_ctrl #(.CNT_W(CNT_W), .AMT_W(AMT_W), .ACK_TIMEOUT(16), .GAP_CYCLES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_coins (load_coins),
    .nickels    (nickels),
    .dimes      (dimes),
    .hop        (hop.slave),
    .nickel_cnt (nickel_cnt),
    .dime_cnt   (dime_cnt),
    .exact_only (exact_only)
  );

  always #5 clk = ~clk;

  typedef struct {
    int n_load, d_load, amt, ack_lat;
    int exp_nick, exp_dime, exp_short, exp_remain, exp_ncnt, exp_dcnt, exp_exact;
  } vec_t;

  vec_t vecs[10];
  int   passed = 0;
  int   total  = 0;

  task automatic check_output(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic do_load(input int n, input int d);
    @(negedge clk);
    load_coins = 1'b1;
    nickels    = CNT_W'(n);
    dimes      = CNT_W'(d);
    @(negedge clk);
    load_coins = 1'b0;
  endtask

  // Hopper model: acks each coin ack_lat cycles after its eject pulse (0 = never acks).
  task automatic apply_stimulus(input int amt, input int ack_lat, input int budget,
                                output int n_ej, output int d_ej, output int both,
                                output int seen, output int s, output int r,
                                output int first_ej, output int done_at);
    int pend;
    pend = 0; n_ej = 0; d_ej = 0; both = 0; seen = 0; s = 0; r = 0;
    first_ej = -1; done_at = -1;
    hop.req_valid = 1'b1;
    hop.req_amt   = AMT_W'(amt);
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      hop.req_valid  = 1'b0;
      hop.hopper_ack = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) hop.hopper_ack = 1'b1;
      end
      if (hop.eject_nickel) n_ej++;
      if (hop.eject_dime) d_ej++;
      if (hop.eject_nickel && hop.eject_dime) both++;
      if (hop.eject_nickel || hop.eject_dime) begin
        if (first_ej < 0) first_ej = c;
        if (ack_lat > 0) pend = ack_lat;
      end
      if (hop.done) begin
        seen    = 1;
        s       = int'(hop.short);
        r       = int'(hop.remain);
        done_at = c;
        break;
      end
    end
    hop.hopper_ack = 1'b0;
  endtask

  initial begin
    int n_ej, d_ej, both, seen, s, r, first_ej, done_at, cnt;

    //            load    amt lat  nick dime short rem ncnt dcnt exact
    vecs[0] = '{1, 2, 1, 1,  1, 0, 0, 0, 0, 2, 1};
    vecs[1] = '{2, 3, 3, 3,  1, 1, 0, 0, 1, 2, 0};
    vecs[2] = '{1, 4, 4, 2,  0, 2, 0, 0, 1, 2, 0};
    vecs[3] = '{0, 1, 3, 1,  0, 1, 1, 1, 0, 0, 1};
`ifdef CHANGE_HOPPER_JAM_RETRY_EN
    vecs[4] = '{1, 1, 2, 0,  0, 2, 1, 2, 1, 0, 1};
`else
    vecs[4] = '{1, 1, 2, 0,  0, 1, 1, 2, 1, 0, 1};
`endif
    vecs[5] = '{3, 0, 2, 5,  2, 0, 0, 0, 1, 0, 1};
    vecs[6] = '{5, 5, 7, 2,  1, 3, 0, 0, 4, 2, 0};
    vecs[7] = '{0, 0, 1, 1,  0, 0, 1, 1, 0, 0, 1};
    vecs[8] = '{4, 2, 0, 1,  0, 0, 0, 0, 4, 2, 0};
    vecs[9] = '{0, 3, 1, 1,  0, 0, 1, 1, 0, 3, 1};

    rst_n = 1'b0; load_coins = 1'b0; nickels = '0; dimes = '0;
    hop.req_valid = 1'b0; hop.req_amt = '0; hop.hopper_ack = 1'b0;

    #2;
    check_output("rst_req_ready", int'(hop.req_ready), 1);
    check_output("rst_exact_only", int'(exact_only), 1);
    check_output("rst_nickel_cnt", int'(nickel_cnt), 0);
    check_output("rst_dime_cnt", int'(dime_cnt), 0);
    check_output("rst_pulses", int'({hop.eject_nickel, hop.eject_dime, hop.done}), 0);
    check_output("rst_remain", int'(hop.remain), 0);
    load_coins = 1'b1;
    #1;
    check_output("rst_ready_follows_load", int'(hop.req_ready), 0);
    load_coins = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // First-eject latency, and an ack during EJECT must be ignored.
    do_load(2, 2);
    hop.req_valid = 1'b1;
    hop.req_amt   = AMT_W'(1);
    @(negedge clk);
    hop.req_valid = 1'b0;
    check_output("lat_select_no_eject", int'({hop.eject_nickel, hop.eject_dime}), 0);
    check_output("lat_busy_not_ready", int'(hop.req_ready), 0);
    @(negedge clk);
    check_output("lat_first_eject_nickel", int'(hop.eject_nickel), 1);
    check_output("lat_no_dime_for_one", int'(hop.eject_dime), 0);
    hop.hopper_ack = 1'b1;
    @(negedge clk);
    hop.hopper_ack = 1'b0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (hop.done || hop.eject_nickel || hop.eject_dime) cnt++;
    end
    check_output("early_ack_ignored", cnt, 0);
    hop.hopper_ack = 1'b1;
    @(negedge clk);
    hop.hopper_ack = 1'b0;
    seen = 0;
    for (int i = 0; i < 10 && seen == 0; i++) begin
      if (hop.done) begin
        seen = 1;
        s = int'(hop.short);
        r = int'(hop.remain);
      end else begin
        @(negedge clk);
      end
    end
    check_output("lat_done_seen", seen, 1);
    check_output("lat_short", s, 0);
    check_output("lat_remain", r, 0);
    check_output("lat_nickel_cnt", int'(nickel_cnt), 1);

    for (int v = 0; v < 10; v++) begin
      do_load(vecs[v].n_load, vecs[v].d_load);
      apply_stimulus(vecs[v].amt, vecs[v].ack_lat, 80, n_ej, d_ej, both, seen, s, r, first_ej, done_at);
      check_output($sformatf("v%0d_done_seen", v), seen, 1);
      check_output($sformatf("v%0d_nickel_pulses", v), n_ej, vecs[v].exp_nick);
      check_output($sformatf("v%0d_dime_pulses", v), d_ej, vecs[v].exp_dime);
      check_output($sformatf("v%0d_both_high", v), both, 0);
      check_output($sformatf("v%0d_short", v), s, vecs[v].exp_short);
      check_output($sformatf("v%0d_remain", v), r, vecs[v].exp_remain);
      check_output($sformatf("v%0d_nickel_cnt", v), int'(nickel_cnt), vecs[v].exp_ncnt);
      check_output($sformatf("v%0d_dime_cnt", v), int'(dime_cnt), vecs[v].exp_dcnt);
      check_output($sformatf("v%0d_exact_only", v), int'(exact_only), vecs[v].exp_exact);
    end

    // Jam timing: done follows the eject after a full timeout (two with retry).
    do_load(1, 1);
    apply_stimulus(2, 0, 80, n_ej, d_ej, both, seen, s, r, first_ej, done_at);
    check_output("jam_first_eject_cycle", first_ej, 1);
`ifdef CHANGE_HOPPER_JAM_RETRY_EN
    check_output("jam_done_cycle", done_at, 35);
`else
    check_output("jam_done_cycle", done_at, 18);
`endif
    check_output("jam_short", s, 1);

    // Load with simultaneous request: load replaces, request is refused.
    @(negedge clk);
    load_coins = 1'b1; nickels = 8'd7; dimes = 8'd6;
    hop.req_valid = 1'b1; hop.req_amt = AMT_W'(1);
    #1;
    check_output("load_blocks_ready", int'(hop.req_ready), 0);
    @(negedge clk);
    load_coins = 1'b0; hop.req_valid = 1'b0;
    check_output("load_replace_nickels", int'(nickel_cnt), 7);
    check_output("load_replace_dimes", int'(dime_cnt), 6);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (hop.done || hop.eject_nickel || hop.eject_dime) cnt++;
    end
    check_output("load_req_not_accepted", cnt, 0);

    // Reset in the middle of WAIT_ACK.
    do_load(3, 3);
    hop.req_valid = 1'b1; hop.req_amt = AMT_W'(2);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      hop.req_valid = 1'b0;
    end
    check_output("midrst_dime_taken", int'(dime_cnt), 2);
    rst_n = 1'b0;
    #1;
    check_output("midrst_nickel_cnt", int'(nickel_cnt), 0);
    check_output("midrst_dime_cnt", int'(dime_cnt), 0);
    check_output("midrst_ready", int'(hop.req_ready), 1);
    check_output("midrst_remain", int'(hop.remain), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (hop.done || hop.eject_nickel || hop.eject_dime) cnt++;
    end
    check_output("midrst_stays_idle", cnt, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
